ppi_bus_sequencer: RTL and testbench

- Clocked bus-cycle sequencer sitting between a synchronous host and the ppichip PPI.
- Converts single-cycle host requests into PPI strobe sequences with programmable setup, strobe and hold timing on CS/RD/WR/A.
- After reset it pulses the PPI reset, then writes a power-up control word before accepting host traffic.
- Single requester, one outstanding transaction.

---
 rtl/ppi_bus_sequencer.sv | 152 +++++++++++++++
 tb/tb_ppi_bus_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ppi_bus_sequencer.sv
// Host-to-PPI bus-cycle sequencer: pulses the PPI reset, writes a power-up control
// word, then turns single-cycle host requests into CS/A/RD/WR strobe sequences.
module ppi_bus_sequencer #(
  parameter int         SETUP_CYC  = 2,
  parameter int         STROBE_CYC = 3,
  parameter int         HOLD_CYC   = 1,
  parameter int         PRST_CYC   = 4,
  parameter logic [7:0] INIT_CW    = 8'h9B,
  parameter int         CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       init_done,
  output logic       ppi_reset,
  output logic       ppi_cs_n,
  output logic       ppi_rd_n,
  output logic       ppi_wr_n,
  output logic [1:0] ppi_a,
  output logic [7:0] ppi_d_out,
  output logic       ppi_d_oe,
  input  logic [7:0] ppi_d_in
);

  typedef enum logic [2:0] {PRST, IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  localparam logic [CNT_W-1:0] PRST_END  = CNT_W'(PRST_CYC);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic             init_q;
  logic [7:0]       cap_q;

  // ppi_a / ppi_d_out double as the latched request address and write data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PRST;
      cnt       <= '0;
      we_q      <= 1'b0;
      init_q    <= 1'b0;
      cap_q     <= 8'h00;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
      init_done <= 1'b0;
      ppi_reset <= 1'b1;
      ppi_cs_n  <= 1'b1;
      ppi_rd_n  <= 1'b1;
      ppi_wr_n  <= 1'b1;
      ppi_a     <= 2'd0;
      ppi_d_out <= 8'h00;
      ppi_d_oe  <= 1'b0;
    end else begin
      case (state)
        PRST: begin
          // Counts up from the cleared value so the pulse spans PRST_CYC full cycles.
          if (cnt == PRST_END) begin
            ppi_reset <= 1'b0;
            we_q      <= 1'b1;
            init_q    <= 1'b1;
            ppi_cs_n  <= 1'b0;
            ppi_a     <= 2'd3;
            ppi_d_out <= INIT_CW;
            ppi_d_oe  <= 1'b1;
            cnt       <= SETUP_LD;
            state     <= SETUP;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            init_q    <= 1'b0;
            if (!req_we && req_addr == 2'd3) begin
              // Control register is write-only: answer without touching the bus.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 8'hFF;
              state     <= DONE;
            end else begin
              ppi_cs_n <= 1'b0;
              ppi_a    <= req_addr;
              ppi_d_oe <= req_we;
              if (req_we) ppi_d_out <= req_wdata;
              cnt      <= SETUP_LD;
              state    <= SETUP;
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            ppi_rd_n <= we_q;
            ppi_wr_n <= !we_q;
            cnt      <= STROBE_LD;
            state    <= STROBE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            ppi_rd_n <= 1'b1;
            ppi_wr_n <= 1'b1;
            if (!we_q) cap_q <= ppi_d_in;
            cnt      <= HOLD_LD;
            state    <= HOLD;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            ppi_cs_n <= 1'b1;
            ppi_d_oe <= 1'b0;
            state    <= DONE;
            if (!init_q) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              if (!we_q) rsp_rdata <= cap_q;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DONE: begin
          rsp_valid <= 1'b0;
          init_done <= 1'b1;
          init_q    <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= PRST;
      endcase
    end
  end

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Directed + random bench for ppi_bus_sequencer; expectations come from the
// timing rules (setup/strobe/hold counts, latencies) rather than the FSM itself.
module tb_ppi_bus_sequencer;

  localparam int         S    = 2;
  localparam int         T    = 3;
  localparam int         H    = 1;
  localparam int         P    = 4;
  localparam logic [7:0] INIT = 8'h9B;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [1:0] req_addr = 2'd0;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       init_done;
  logic       ppi_reset;
  logic       ppi_cs_n;
  logic       ppi_rd_n;
  logic       ppi_wr_n;
  logic [1:0] ppi_a;
  logic [7:0] ppi_d_out;
  logic       ppi_d_oe;
  logic [7:0] ppi_d_in = 8'h00;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] cur_din = 8'h00;

  ppi_bus_sequencer #(
    .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H), .PRST_CYC(P),
    .INIT_CW(INIT), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .init_done(init_done), .ppi_reset(ppi_reset),
    .ppi_cs_n(ppi_cs_n), .ppi_rd_n(ppi_rd_n), .ppi_wr_n(ppi_wr_n),
    .ppi_a(ppi_a), .ppi_d_out(ppi_d_out), .ppi_d_oe(ppi_d_oe),
    .ppi_d_in(ppi_d_in)
  );

  always #5 clk = ~clk;

  // PPI model: valid data only while RD is low, inverted garbage otherwise.
  always @(negedge clk) ppi_d_in = ppi_rd_n ? ~cur_din : cur_din;

  // Bus protocol monitor.
  logic       prev_lo = 1'b0;
  logic [1:0] prev_a = 2'd0;
  logic [7:0] prev_d = 8'h00;
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      assert (!(!ppi_rd_n && !ppi_wr_n) && !((!ppi_rd_n || !ppi_wr_n) && ppi_cs_n) &&
              !(prev_lo && !ppi_cs_n && (ppi_a !== prev_a || ppi_d_out !== prev_d)))
      else begin
        errors++;
        $error("FAIL protocol: cs_n=%0b rd_n=%0b wr_n=%0b a=%0h/%0h d=%0h/%0h",
               ppi_cs_n, ppi_rd_n, ppi_wr_n, ppi_a, prev_a, ppi_d_out, prev_d);
      end
      prev_lo = !ppi_cs_n;
      prev_a  = ppi_a;
      prev_d  = ppi_d_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Holds reset, checks reset values, releases it at a negedge, checks the power-up write.
  task automatic power_up(input string tag);
    int n, cs_lo, wr_lo, rd_lo, bad, rv;
    reset = 1'b0;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, " rst ppi_reset"}, ppi_reset, 1);
    chk({tag, " rst strobes"}, {ppi_cs_n, ppi_rd_n, ppi_wr_n, ppi_d_oe}, 4'b1110);
    chk({tag, " rst host"}, {req_ready, rsp_valid, rsp_err, init_done}, 4'b0000);
    chk({tag, " rst buses"}, {ppi_a, ppi_d_out, rsp_rdata}, 18'h0);
    reset = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ppi_reset) n++;
      else break;
    end
    chk({tag, " ppi_reset cycles"}, n, P);
    cs_lo = 0; wr_lo = 0; rd_lo = 0; bad = 0; rv = 0;
    for (int k = 0; k < 30 && !init_done; k++) begin
      if (!ppi_cs_n) begin
        cs_lo++;
        if (ppi_a !== 2'd3 || ppi_d_out !== INIT || ppi_d_oe !== 1'b1) bad++;
      end
      if (!ppi_wr_n) wr_lo++;
      if (!ppi_rd_n) rd_lo++;
      if (rsp_valid) rv++;
      @(negedge clk);
    end
    chk({tag, " init_done"}, init_done, 1);
    chk({tag, " init cs low"}, cs_lo, S + T + H);
    chk({tag, " init wr/rd low"}, {wr_lo[7:0], rd_lo[7:0]}, {8'(T), 8'd0});
    chk({tag, " init addr/data"}, bad, 0);
    chk({tag, " init no rsp"}, rv, 0);
    chk({tag, " ready"}, req_ready, 1);
  endtask

  // Presents one request and checks the bus cycle and response against the rules.
  task automatic do_txn(input string tag, input logic we, input logic [1:0] addr,
                        input logic [7:0] wd, input logic [7:0] din);
    logic illegal, rdy, acc;
    int lat, cs_lo, rd_lo, wr_lo, bad;
    illegal = !we && addr == 2'd3;
    cur_din = din;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rdy = req_ready;
      @(negedge clk);
      if (rdy) begin acc = 1'b1; break; end
    end
    chk({tag, " accepted"}, acc, 1);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = 2'($urandom); req_wdata = 8'($urandom);
    lat = 0; cs_lo = 0; rd_lo = 0; wr_lo = 0; bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (rsp_valid) begin lat = k; break; end
      if (!ppi_cs_n) begin
        cs_lo++;
        if (ppi_a !== addr || ppi_d_oe !== we || (we && ppi_d_out !== wd)) bad++;
      end
      if (!ppi_rd_n) rd_lo++;
      if (!ppi_wr_n) wr_lo++;
      @(negedge clk);
    end
    chk({tag, " latency"}, lat, illegal ? 1 : S + T + H + 1);
    chk({tag, " cs low"}, cs_lo, illegal ? 0 : S + T + H);
    chk({tag, " rd low"}, rd_lo, (!we && !illegal) ? T : 0);
    chk({tag, " wr low"}, wr_lo, we ? T : 0);
    chk({tag, " addr/data/oe"}, bad, 0);
    chk({tag, " rsp_err"}, rsp_err, illegal);
    if (!we) chk({tag, " rsp_rdata"}, rsp_rdata, illegal ? 8'hFF : din);
    @(negedge clk);
    chk({tag, " rsp pulse"}, {rsp_valid, req_ready}, 2'b01);
    if (!we) chk({tag, " rdata held"}, rsp_rdata, illegal ? 8'hFF : din);
  endtask

  initial begin
    logic rdy, found;
    int acc_n, rsp_n, a2, r1, gap, hi_run;
    logic seen_lo;

    power_up("pu");
    do_txn("wrB", 1'b1, 2'd1, 8'h5A, 8'h00);
    do_txn("rdA", 1'b0, 2'd0, 8'h00, 8'hC3);
    do_txn("rd3", 1'b0, 2'd3, 8'h00, 8'h11);
    do_txn("rdC", 1'b0, 2'd2, 8'h00, 8'h3E);

    // Back-to-back: req_valid held high across two requests.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd2; req_wdata = 8'h3C;
    acc_n = 0; rsp_n = 0; a2 = 0; r1 = 0; gap = 99; hi_run = 0; seen_lo = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      rdy = req_ready;
      @(negedge clk);
      if (rdy && req_valid) begin
        acc_n++;
        if (acc_n == 2) begin a2 = k; req_valid = 1'b0; end
      end
      if (rsp_valid) begin rsp_n++; if (rsp_n == 1) r1 = k; end
      if (ppi_cs_n) hi_run++;
      else begin
        if (seen_lo && hi_run > 0 && hi_run < gap) gap = hi_run;
        seen_lo = 1'b1;
        hi_run = 0;
      end
    end
    chk("b2b accepts", acc_n, 2);
    chk("b2b responses", rsp_n, 2);
    chk("b2b order", (a2 > r1), 1);
    chk("b2b cs gap", (gap >= 1 && gap != 99), 1);

    for (int i = 0; i < 8; i++)
      do_txn("rand", 1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));

    // Reset asserted while WR is low.
    cur_din = 8'h00;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd1; req_wdata = 8'h77;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!req_ready) req_valid = 1'b0;
      if (!ppi_wr_n) begin found = 1'b1; break; end
    end
    req_valid = 1'b0;
    chk("abort reached strobe", found, 1);
    #3 reset = 1'b0;
    #1;
    chk("abort strobes", {ppi_cs_n, ppi_wr_n, ppi_rd_n, ppi_d_oe}, 4'b1110);
    chk("abort flags", {init_done, ppi_reset}, 2'b01);
    @(negedge clk);
    power_up("rerun");
    do_txn("post wr", 1'b1, 2'd0, 8'hA5, 8'h00);
    do_txn("post rd", 1'b0, 2'd1, 8'h00, 8'h69);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
